// File: rtl/serial_command_issuer_if.sv
// rtl/serial_command_issuer_if.sv - command/payload, UART byte and response signals of the serial command issuer
interface serial_command_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_code;
  logic [31:0] cmd_length;
  logic [31:0] cmd_resp_words;
  logic [31:0] payload_word;
  logic        payload_valid;
  logic        payload_ready;
  logic [7:0]  TX;
  logic        start_TX;
  logic        TX_ready;
  logic [7:0]  RX;
  logic        RX_ready;
  logic [31:0] resp_word;
  logic        resp_valid;
  logic        done;
  logic        timeout;
  logic        busy;

  modport master (
    output cmd_valid, cmd_code, cmd_length, cmd_resp_words, payload_word, payload_valid,
    output TX_ready, RX, RX_ready,
    input  cmd_ready, payload_ready, TX, start_TX, resp_word, resp_valid, done, timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_length, cmd_resp_words, payload_word, payload_valid,
    input  TX_ready, RX, RX_ready,
    output cmd_ready, payload_ready, TX, start_TX, resp_word, resp_valid, done, timeout, busy
  );
endinterface

// File: rtl/serial_command_issuer.sv
// rtl/serial_command_issuer.sv - serializes {length, command, payload} to a UART and collects response words
// Define SERIAL_ISSUER_TIMEOUT_EN to enable the inter-byte response timeout.
module serial_command_issuer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input logic                    clk,
  input logic                    rst,
  serial_command_issuer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_LEN,
    S_SEND_CMD,
    S_SEND_PAYLOAD,
    S_RECV
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_cmd_code;
  logic [31:0] r_len;
  logic [31:0] r_resp_words;
  logic [31:0] r_shift;
  logic [31:0] r_pay_cnt;
  logic [31:0] r_resp_cnt;
  logic [23:0] r_word;
  logic [31:0] r_resp_word;
  logic [1:0]  r_byte_idx;
  logic [1:0]  r_rx_idx;
  logic [7:0]  r_tx;
  logic        r_full;
  logic        r_guard;
  logic        r_resp_valid;
  logic        r_done;

  logic        w_has_byte;
  logic        w_issue;
  logic        w_last_byte;
  logic        w_accept;
  logic        w_pay_take;
  logic        w_resp_last;
  logic        w_recv_active;
  logic        w_recv_done;
  logic        w_rx_take;
  logic        w_to_hit;

`ifdef SERIAL_ISSUER_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= 32'd0;
    end else if (r_state != S_RECV || bus.RX_ready) begin
      r_to_cnt <= 32'd0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  // A word just delivered already reset the silence window, so it never collides with expiry.
  assign w_to_hit = !rst && w_recv_active && !r_resp_valid && !bus.RX_ready &&
                    (r_to_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_has_byte    = 1'b0;
    w_issue       = 1'b0;
    w_last_byte   = 1'b0;
    w_accept      = 1'b0;
    w_pay_take    = 1'b0;
    w_resp_last   = 1'b0;
    w_recv_active = 1'b0;
    w_recv_done   = 1'b0;
    w_rx_take     = 1'b0;
    w_next        = r_state;

    w_has_byte    = (r_state == S_SEND_LEN) || (r_state == S_SEND_CMD) ||
                    ((r_state == S_SEND_PAYLOAD) && r_full);
    w_issue       = !rst && w_has_byte && bus.TX_ready && !r_guard;
    w_last_byte   = w_issue && (r_byte_idx == 2'd3);
    w_accept      = (r_state == S_IDLE) && bus.cmd_valid;
    w_pay_take    = (r_state == S_SEND_PAYLOAD) && !r_full && bus.payload_valid;
    w_resp_last   = r_resp_valid && (r_resp_cnt == r_resp_words);
    w_recv_active = (r_state == S_RECV) && (r_resp_words != 32'd0) && !w_resp_last;
    w_recv_done   = (r_state == S_RECV) && ((r_resp_words == 32'd0) || w_resp_last);
    w_rx_take     = w_recv_active && bus.RX_ready;

    unique case (r_state)
      S_IDLE:         if (w_accept) w_next = S_SEND_LEN;
      S_SEND_LEN:     if (w_last_byte) w_next = S_SEND_CMD;
      S_SEND_CMD:     if (w_last_byte) w_next = (r_len != 32'd0) ? S_SEND_PAYLOAD : S_RECV;
      S_SEND_PAYLOAD: if (w_last_byte && (r_pay_cnt + 32'd1 == r_len)) w_next = S_RECV;
      S_RECV:         if (w_recv_done || w_to_hit) w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_code   <= 32'd0;
      r_len        <= 32'd0;
      r_resp_words <= 32'd0;
      r_shift      <= 32'd0;
      r_pay_cnt    <= 32'd0;
      r_resp_cnt   <= 32'd0;
      r_word       <= 24'd0;
      r_resp_word  <= 32'd0;
      r_byte_idx   <= 2'd0;
      r_rx_idx     <= 2'd0;
      r_tx         <= 8'h00;
      r_full       <= 1'b0;
      r_guard      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_done       <= w_recv_done;

      if (w_accept) begin
        r_cmd_code   <= bus.cmd_code;
        r_len        <= bus.cmd_length;
        r_resp_words <= bus.cmd_resp_words;
        r_shift      <= bus.cmd_length;
        r_byte_idx   <= 2'd0;
        r_pay_cnt    <= 32'd0;
        r_resp_cnt   <= 32'd0;
        r_rx_idx     <= 2'd0;
        r_full       <= 1'b0;
      end

      // Guard blocks re-issue until the UART has visibly taken the byte.
      if (w_issue) begin
        r_tx       <= r_shift[31:24];
        r_shift    <= {r_shift[23:0], 8'h00};
        r_byte_idx <= r_byte_idx + 2'd1;
        r_guard    <= 1'b1;
      end else if (!bus.TX_ready) begin
        r_guard    <= 1'b0;
      end

      if (w_last_byte) begin
        unique case (r_state)
          S_SEND_LEN: r_shift <= r_cmd_code;
          S_SEND_PAYLOAD: begin
            r_full    <= 1'b0;
            r_pay_cnt <= r_pay_cnt + 32'd1;
          end
          default: ;
        endcase
      end

      if (w_pay_take) begin
        r_shift <= bus.payload_word;
        r_full  <= 1'b1;
      end

      if (w_rx_take) begin
        r_word   <= {r_word[15:0], bus.RX};
        r_rx_idx <= r_rx_idx + 2'd1;
        if (r_rx_idx == 2'd3) begin
          r_resp_word  <= {r_word, bus.RX};
          r_resp_valid <= 1'b1;
          r_resp_cnt   <= r_resp_cnt + 32'd1;
        end
      end

      if (w_to_hit) begin
        r_rx_idx <= 2'd0;
      end
    end
  end

  assign bus.cmd_ready     = (r_state == S_IDLE);
  assign bus.payload_ready = (r_state == S_SEND_PAYLOAD) && !r_full;
  assign bus.start_TX      = w_issue;
  assign bus.TX            = w_issue ? r_shift[31:24] : r_tx;
  assign bus.resp_word     = r_resp_word;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.done          = r_done || w_to_hit;
  assign bus.timeout       = w_to_hit;
  assign bus.busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_command_issuer.sv
// tb/tb_serial_command_issuer.sv - directed self-checking bench for serial_command_issuer
module tb_serial_command_issuer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  serial_command_issuer_if bus();

  serial_command_issuer #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: TX_ready lingers high one cycle after a strobe, then drops for three.
  logic hold_tx = 1'b0;
  int   uart_cnt = 0;
  always @(posedge clk) begin
    if (bus.start_TX) uart_cnt <= 4;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign bus.TX_ready = !hold_tx && (uart_cnt == 0 || uart_cnt == 4);

  logic [7:0]  tx_log[$];
  int          tx_cyc[$];
  logic [31:0] resp_log[$];
  logic [7:0]  exp_q[$];
  int resp_cyc = 0, done_cyc = 0, timeout_cyc = 0, rx_cyc = 0;
  int timeout_cnt = 0, overlap = 0;

  always @(negedge clk) begin
    if (bus.start_TX) begin
      tx_log.push_back(bus.TX);
      tx_cyc.push_back(cyc);
    end
    if (bus.resp_valid) begin
      resp_log.push_back(bus.resp_word);
      resp_cyc = cyc;
    end
    if (bus.done) done_cyc = cyc;
    if (bus.timeout) begin
      timeout_cnt++;
      timeout_cyc = cyc;
    end
    if (bus.done && bus.resp_valid) overlap++;
    if (bus.RX_ready) rx_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    tx_log.delete();
    tx_cyc.delete();
    resp_log.delete();
    exp_q.delete();
  endtask

  task automatic exp_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic chk_bytes(input string tag);
    chk({tag, "_count"}, 32'(tx_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 32'(tx_log[i]), 32'(exp_q[i]));
  endtask

  task automatic chk_gap(input string tag);
    int mg = 1000;
    for (int i = 1; i < tx_cyc.size(); i++)
      if (tx_cyc[i] - tx_cyc[i-1] < mg) mg = tx_cyc[i] - tx_cyc[i-1];
    chk(tag, 32'(mg >= 2), 32'd1);
  endtask

  task automatic accept_cmd(input logic [31:0] code, input logic [31:0] len, input logic [31:0] resp);
    @(posedge clk); #1;
    bus.cmd_code = code; bus.cmd_length = len; bus.cmd_resp_words = resp; bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_at_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_code = 32'hFFFF_FFFF; bus.cmd_length = 32'hFFFF_FFFF; bus.cmd_resp_words = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_tx(input int n);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = (tx_log.size() >= n);
    end
    if (!ok) chk("wait_tx_bound", 32'(tx_log.size()), 32'(n));
  endtask

  task automatic push_payload(input logic [31:0] w);
    bit ok = 1'b0;
    @(posedge clk); #1;
    bus.payload_word = w; bus.payload_valid = 1'b1;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.payload_ready === 1'b1);
    end
    @(posedge clk); #1;
    bus.payload_valid = 1'b0;
    if (!ok) chk("payload_taken", 32'(ok), 32'd1);
  endtask

  task automatic feed_rx(input logic [7:0] b);
    @(posedge clk); #1;
    bus.RX = b; bus.RX_ready = 1'b1;
    @(posedge clk); #1;
    bus.RX_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.done === 1'b1);
    end
    chk(tag, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] info_word(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    if (k == 0) return 32'h0a5a4950;
    if (k == 27) return 32'h0000_0000;
    return {kb, 8'hA5, ~kb, 8'h3C};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    bit          ok;
    int          n;
    int          exp_to;

    bus.cmd_valid = 1'b0; bus.cmd_code = 32'd0; bus.cmd_length = 32'd0; bus.cmd_resp_words = 32'd0;
    bus.payload_word = 32'd0; bus.payload_valid = 1'b0; bus.RX = 8'h00; bus.RX_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_payload_ready", 32'(bus.payload_ready), 32'd0);
    chk("rst_start_TX", 32'(bus.start_TX), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_TX", 32'(bus.TX), 32'h00);
    chk("rst_resp_word", bus.resp_word, 32'h0);

    // INFO: no payload, 28 response words
    clear_logs(); exp_word(32'd0); exp_word(32'd1);
    accept_cmd(32'd1, 32'd0, 32'd28);
    wait_tx(8);
    chk_bytes("info_tx");
    for (int k = 0; k < 28; k++) begin
      w = info_word(k);
      feed_rx(w[31:24]); feed_rx(w[23:16]); feed_rx(w[15:8]); feed_rx(w[7:0]);
    end
    wait_done("info_done");
    chk("info_resp_count", 32'(resp_log.size()), 32'd28);
    chk("info_first", resp_log[0], 32'h0a5a4950);
    chk("info_last", resp_log[27], 32'h0000_0000);
    for (int k = 1; k < 27 && k < resp_log.size(); k++)
      chk($sformatf("info_w%0d", k), resp_log[k], info_word(k));
    chk("info_done_after_resp", 32'(done_cyc - resp_cyc), 32'd1);

    // UPLOAD: two payload words, no response; a second cmd_valid while busy is ignored
    clear_logs(); exp_word(32'd2); exp_word(32'd2); exp_word(32'h0000_0010); exp_word(32'hDEAD_BEEF);
    accept_cmd(32'd2, 32'd2, 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_code = 32'h9; bus.cmd_length = 32'h5; bus.cmd_resp_words = 32'h3;
    push_payload(32'h0000_0010);
    push_payload(32'hDEAD_BEEF);
    bus.cmd_valid = 1'b0;
    wait_done("upload_done");
    chk_bytes("upload_tx");
    chk("upload_no_resp", 32'(resp_log.size()), 32'd0);
    chk("upload_done_lat", 32'(done_cyc - tx_cyc[15]), 32'd2);
    chk_gap("upload_gap");

    // TX backpressure after byte 5
    clear_logs(); exp_word(32'd1); exp_word(32'd3); exp_word(32'hCAFE_F00D);
    accept_cmd(32'd3, 32'd1, 32'd0);
    wait_tx(5);
    @(posedge clk); #1;
    hold_tx = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("hold_no_strobe", 32'(tx_log.size()), 32'd5);
    hold_tx = 1'b0;
    push_payload(32'hCAFE_F00D);
    wait_done("bp_done");
    chk_bytes("bp_tx");
    chk_gap("bp_gap");

    // Stray RX while idle, then a one-word response
    clear_logs(); exp_word(32'd0); exp_word(32'd4);
    feed_rx(8'hAA); feed_rx(8'hBB); feed_rx(8'hCC);
    @(negedge clk);
    chk("stray_no_resp", 32'(resp_log.size()), 32'd0);
    chk("stray_idle", 32'(bus.busy), 32'd0);
    accept_cmd(32'd4, 32'd0, 32'd1);
    wait_tx(8);
    feed_rx(8'h12); feed_rx(8'h34); feed_rx(8'h56); feed_rx(8'h78);
    wait_done("stray_done");
    chk_bytes("stray_tx");
    chk("stray_resp_count", 32'(resp_log.size()), 32'd1);
    chk("stray_resp_word", resp_log[0], 32'h1234_5678);

    // Reset during the second payload word, then a fresh command
    clear_logs();
    accept_cmd(32'd5, 32'd3, 32'd0);
    push_payload(32'h1111_1111);
    push_payload(32'h2222_2222);
    wait_tx(13);
    @(posedge clk); #1;
    rst = 1'b1;
    n = tx_log.size();
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_payload_ready", 32'(bus.payload_ready), 32'd0);
    chk("mid_rst_start_TX", 32'(bus.start_TX), 32'd0);
    chk("mid_rst_TX", 32'(bus.TX), 32'h00);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_trailing", 32'(tx_log.size()), 32'(n));
    clear_logs(); exp_word(32'd1); exp_word(32'd6); exp_word(32'h0BAD_F00D);
    accept_cmd(32'd6, 32'd1, 32'd0);
    push_payload(32'h0BAD_F00D);
    wait_done("fresh_done");
    chk_bytes("fresh_tx");

    exp_to = 0;
`ifdef SERIAL_ISSUER_TIMEOUT_EN
    // Two bytes then silence
    clear_logs();
    exp_to = 1;
    accept_cmd(32'd7, 32'd0, 32'd1);
    wait_tx(8);
    feed_rx(8'hAB); feed_rx(8'hCD);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = (bus.timeout === 1'b1);
    end
    chk("to_seen", 32'(ok), 32'd1);
    chk("to_with_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("to_cmd_ready_next", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    chk("to_latency", 32'(timeout_cyc - rx_cyc), 32'd100);
    chk("to_no_resp", 32'(resp_log.size()), 32'd0);
`endif
    chk("timeout_pulses", 32'(timeout_cnt), 32'(exp_to));
    chk("done_resp_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
